// File: rtl/mux_2to1_if.sv
// Bus bundle for the 2-to-1 selector: data/select in, selected data and select-activity status out.
interface mux_2to1_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             sel;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;
    logic             sel_toggle;
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output sel, in0, in1,
        input  out, out_q, sel_q, sel_toggle, toggle_cnt
    );

    modport slave (
        input  sel, in0, in1,
        output out, out_q, sel_q, sel_toggle, toggle_cnt
    );
endinterface

// File: rtl/mux_2to1.sv
// 2-to-1 data selector with registered shadow copy, select-change pulse and saturating switch counter.
// Optional MUX_2TO1_REG_OUT_EN: drive out from the register instead of the combinational path.
module mux_2to1 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic        clk,
    input logic        rst_n,
    mux_2to1_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] selected_c;
    logic             toggle_c;
    logic [WIDTH-1:0] out_q_r;
    logic             sel_q_r;
    logic [CNT_W-1:0] cnt_r;

    assign selected_c = bus.sel ? bus.in1 : bus.in0;

    // Gated by rst_n so a switch coincident with reset is neither flagged nor counted.
    assign toggle_c = (bus.sel != sel_q_r) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q_r <= '0;
            sel_q_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            out_q_r <= selected_c;
            sel_q_r <= bus.sel;
            if (toggle_c && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

`ifdef MUX_2TO1_REG_OUT_EN
    assign bus.out = out_q_r;
`else
    assign bus.out = selected_c;
`endif

    assign bus.out_q      = out_q_r;
    assign bus.sel_q      = sel_q_r;
    assign bus.sel_toggle = toggle_c;
    assign bus.toggle_cnt = cnt_r;
endmodule

// File: tb/tb_mux_2to1.sv
// Directed-vector scoreboard bench: two selectors (CNT_W=8 and CNT_W=2) driven identically.
module tb_mux_2to1;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_2to1_if #(.WIDTH(4), .CNT_W(8)) bus8 ();
    mux_2to1_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

    mux_2to1 #(.WIDTH(4), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    mux_2to1 #(.WIDTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // e_out is the combinational selection of the row's inputs; registered fields
    // reflect the edge that captured the previous row.
    typedef struct packed {
        logic       rst_n;
        logic       sel;
        logic [3:0] in0;
        logic [3:0] in1;
        logic [3:0] e_out;
        logic       e_tog;
        logic [3:0] e_out_q;
        logic       e_sel_q;
        logic [7:0] e_cnt8;
        logic [1:0] e_cnt2;
    } vec_t;

    localparam int unsigned NVEC = 15;
    vec_t vecs [NVEC];
    vec_t exp_q [$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n    = v.rst_n;
        bus8.sel = v.sel;
        bus8.in0 = v.in0;
        bus8.in1 = v.in1;
        bus2.sel = v.sel;
        bus2.in0 = v.in0;
        bus2.in1 = v.in1;
    endtask

    // Monitor: compare every pending expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            logic [3:0] e_out;
            e = exp_q.pop_front();
`ifdef MUX_2TO1_REG_OUT_EN
            e_out = e.e_out_q;
`else
            e_out = e.e_out;
`endif
            check("out",         64'(bus8.out),        64'(e_out));
            check("sel_toggle",  64'(bus8.sel_toggle), 64'(e.e_tog));
            check("out_q",       64'(bus8.out_q),      64'(e.e_out_q));
            check("sel_q",       64'(bus8.sel_q),      64'(e.e_sel_q));
            check("toggle_cnt8", 64'(bus8.toggle_cnt), 64'(e.e_cnt8));
            check("toggle_cnt2", 64'(bus2.toggle_cnt), 64'(e.e_cnt2));
            check("sel_toggle2", 64'(bus2.sel_toggle), 64'(e.e_tog));
            check("out_q2",      64'(bus2.out_q),      64'(e.e_out_q));
        end
    end

    initial begin
        //                rst sel in0   in1   out   tog   out_q sel_q cnt8   cnt2
        vecs[0]  = '{1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 8'd0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 4'hA, 4'h5, 4'hA, 1'b0, 4'h0, 1'b0, 8'd0, 2'd0};
        vecs[2]  = '{1'b1, 1'b1, 4'hA, 4'h5, 4'h5, 1'b1, 4'hA, 1'b0, 8'd0, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 4'hA, 4'h5, 4'hA, 1'b1, 4'h5, 1'b1, 8'd1, 2'd1};
        vecs[4]  = '{1'b1, 1'b1, 4'hA, 4'h5, 4'h5, 1'b1, 4'hA, 1'b0, 8'd2, 2'd2};
        vecs[5]  = '{1'b1, 1'b1, 4'h3, 4'hC, 4'hC, 1'b0, 4'h5, 1'b1, 8'd3, 2'd3};
        vecs[6]  = '{1'b1, 1'b1, 4'h6, 4'h9, 4'h9, 1'b0, 4'hC, 1'b1, 8'd3, 2'd3};
        vecs[7]  = '{1'b1, 1'b0, 4'h3, 4'hC, 4'h3, 1'b1, 4'h9, 1'b1, 8'd3, 2'd3};
        vecs[8]  = '{1'b1, 1'b1, 4'h3, 4'hC, 4'hC, 1'b1, 4'h3, 1'b0, 8'd4, 2'd3};
        vecs[9]  = '{1'b1, 1'b0, 4'h3, 4'hC, 4'h3, 1'b1, 4'hC, 1'b1, 8'd5, 2'd3};
        vecs[10] = '{1'b0, 1'b1, 4'h3, 4'hC, 4'hC, 1'b0, 4'h3, 1'b0, 8'd6, 2'd3};
        vecs[11] = '{1'b1, 1'b1, 4'h3, 4'hC, 4'hC, 1'b1, 4'h0, 1'b0, 8'd0, 2'd0};
        vecs[12] = '{1'b1, 1'b1, 4'h7, 4'h8, 4'h8, 1'b0, 4'hC, 1'b1, 8'd1, 2'd1};
        vecs[13] = '{1'b1, 1'b0, 4'hE, 4'h8, 4'hE, 1'b1, 4'h8, 1'b1, 8'd1, 2'd1};
        vecs[14] = '{1'b1, 1'b0, 4'hE, 4'h8, 4'hE, 1'b0, 4'hE, 1'b0, 8'd2, 2'd2};

        // Reset held for two edges with sel=1, in1=0xF.
        drive(vecs[0]);
        repeat (2) @(posedge clk);

        for (int i = 0; i < int'(NVEC); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
